// File: rtl/ysyx_22050612_decode_stage.sv
// RV32/RV64 IM decode stage: combinational decode of the incoming word into a
// valid/ready pipeline register, plus a wrapping count of instructions handed on.
module ysyx_22050612_decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_wen,
  output logic             out_ebreak,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decode_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic is64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       is_shift;
  logic       no_wb;
  logic [2:0] fmt;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  always_comb begin
    legal    = 1'b0;
    fmt      = FMT_I;
    is_shift = 1'b0;
    no_wb    = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        legal = 1'b1;
        fmt   = FMT_U;
      end
      OP_JAL: begin
        legal = 1'b1;
        fmt   = FMT_J;
      end
      OP_JALR:   legal = (funct3 == 3'b000);
      OP_BRANCH: begin
        legal = (funct3[2:1] != 2'b01);
        fmt   = FMT_B;
      end
      OP_LOAD:   legal = (funct3 != 3'b111) && (is64 || (funct3 != 3'b011 && funct3 != 3'b110));
      OP_STORE: begin
        legal = !funct3[2] && (is64 || funct3[1:0] != 2'b11);
        fmt   = FMT_S;
      end
      OP_IMM: begin
        if (funct3[1:0] == 2'b01) begin
          // RV32 has only a 5-bit shamt, so inst[25] must stay clear there
          is_shift = 1'b1;
          legal    = (in_inst[31:26] == 6'b000000 ||
                      (funct3[2] && in_inst[31:26] == 6'b010000)) &&
                     (is64 || !in_inst[25]);
        end else begin
          legal = 1'b1;
        end
      end
      OP_IMM_32: legal = is64 && (funct3 == 3'b000 ||
                                  (funct3 == 3'b001 && funct7 == 7'b0000000) ||
                                  (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)));
      OP_OP: begin
        fmt   = FMT_R;
        legal = funct7 == 7'b0000000 || funct7 == 7'b0000001 ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_32: begin
        fmt   = FMT_R;
        legal = is64 && (
                  (funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                  (funct7 == 7'b0000001 && (funct3 == 3'b000 || funct3[2])));
      end
      OP_FENCE: begin
        legal = 1'b1;
        no_wb = 1'b1;
      end
      OP_SYSTEM: begin
        legal = (in_inst == INST_ECALL) || (in_inst == INST_EBREAK);
        no_wb = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sel;

  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm_sh = XLEN'({is64 & in_inst[25], in_inst[24:20]});

  always_comb begin
    imm_sel = '0;
    case (fmt)
      FMT_I:   imm_sel = is_shift ? imm_sh : imm_i;
      FMT_S:   imm_sel = imm_s;
      FMT_B:   imm_sel = imm_b;
      FMT_U:   imm_sel = imm_u;
      FMT_J:   imm_sel = imm_j;
      default: imm_sel = '0;
    endcase
  end

  logic accept;
  logic handoff;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  // flush beats a same-cycle accept, but a handoff in that cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_imm     <= '0;
      out_fmt     <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_wen     <= 1'b0;
      out_ebreak  <= 1'b0;
      out_illegal <= 1'b0;
      decode_cnt  <= '0;
    end else begin
      if (handoff) decode_cnt <= decode_cnt + CNT_W'(1);

      if (flush)        out_valid <= 1'b0;
      else if (accept)  out_valid <= 1'b1;
      else if (handoff) out_valid <= 1'b0;

      if (accept && !flush) begin
        out_pc      <= in_pc;
        out_inst    <= in_inst;
        out_imm     <= legal ? imm_sel : '0;
        out_fmt     <= legal ? fmt : FMT_R;
        out_rd      <= in_inst[11:7];
        out_rs1     <= in_inst[19:15];
        out_rs2     <= in_inst[24:20];
        out_wen     <= legal && !no_wb && (in_inst[11:7] != 5'd0) && fmt != FMT_S && fmt != FMT_B;
        out_ebreak  <= (in_inst == INST_EBREAK);
        out_illegal <= !legal;
      end
    end
  end

endmodule
